// File: rtl/uart_rx_deserializer_if.sv
// Receive-side bundle for the host-link UART: serial line in, byte stream
// out on valid/ready, plus error pulses and busy status.
interface uart_rx_deserializer_if;
  logic       rx;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  // master: the receiver, which sources the byte stream
  modport master (
    input  rx,
    input  out_ready,
    output out_data,
    output out_valid,
    output framing_err,
    output overrun,
    output busy
  );

  // slave: the line driver and byte consumer
  modport slave (
    output rx,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  framing_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: majority-voted mid-bit sampling, one-byte holding
// register on valid/ready, framing-error and overrun pulses.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  uart_rx_deserializer_if.master io_bus
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_V0   = CW'(H - 1);
  localparam logic [CW-1:0] C_V1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rx_meta, r_rx_s, r_rx_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_v0, r_v1;
  logic [7:0]    r_data;
  logic          r_valid, r_ferr, r_ovr, r_busy;
  logic          w_fall, w_dec, w_vote;
  logic          w_clr_cnt, w_clr_idx, w_shift, w_commit, w_ferr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= io_bus.rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s;
  assign w_dec  = (r_cnt == C_DEC);
  // Third vote is the live sample at H+1; the first two were captured earlier.
  assign w_vote = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);

  always_comb begin
    w_state_nxt = r_state;
    w_clr_cnt   = 1'b0;
    w_clr_idx   = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_clr_cnt   = 1'b1;
        end
      end
      S_START: begin
        if (w_dec) begin
          if (!w_vote) begin
            w_state_nxt = S_DATA;
            w_clr_idx   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_dec) begin
          w_shift = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so the next start edge is never missed.
        if (w_dec) begin
          w_state_nxt = S_IDLE;
          w_commit    = w_vote;
          w_ferr      = ~w_vote;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_v0      <= 1'b1;
      r_v1      <= 1'b1;
    end else begin
      if (w_clr_cnt)              r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      if (w_clr_idx)    r_bit_idx <= '0;
      else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift)         r_shift <= {w_vote, r_shift[7:1]};
      if (r_cnt == C_V0)   r_v0    <= r_rx_s;
      if (r_cnt == C_V1)   r_v1    <= r_rx_s;
    end
  end

  // Holding register: a commit while full is only accepted if the old byte leaves now.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_commit & r_valid & ~io_bus.out_ready;
      if (w_commit && (!r_valid || io_bus.out_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && io_bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.out_data    = r_data;
  assign io_bus.out_valid   = r_valid;
  assign io_bus.framing_err = r_ferr;
  assign io_bus.overrun     = r_ovr;
  assign io_bus.busy        = r_busy;

endmodule
